// File: rtl/tank_hit_detector_if.sv
// Bundles the pixel-path inputs and the icon-block handshake of one tank hit detector.
// master: the driving side (timing generator / icon block); slave: the detector.
interface tank_hit_detector_if;
    logic [11:0] pixel_column;
    logic [11:0] pixel_row;
    logic [1:0]  tank_icon;
    logic [1:0]  shell_icon;
    logic        burst;
    logic        tank_reset;
    logic        hit;
    logic        shell_clear;
    logic [7:0]  hit_count;
    logic        busy;

    modport master (
        output pixel_column, pixel_row, tank_icon, shell_icon, burst, tank_reset,
        input  hit, shell_clear, hit_count, busy
    );

    modport slave (
        input  pixel_column, pixel_row, tank_icon, shell_icon, burst, tank_reset,
        output hit, shell_clear, hit_count, busy
    );
endinterface

// File: rtl/tank_hit_detector.sv
// Counts tank/projectile pixel overlap per frame, fires a one-cycle hit at frame end,
// then locks out until the icon block finishes its burst and requests a respawn.
module tank_hit_detector #(
    parameter int unsigned H_LAST        = 1023,
    parameter int unsigned V_LAST        = 767,
    parameter int unsigned OVERLAP_MIN   = 4,
    parameter int unsigned BURST_TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                reset,
    tank_hit_detector_if.slave  bus
);

    typedef enum logic [1:0] {
        ARMED      = 2'd0,
        FIRE       = 2'd1,
        WAIT_BURST = 2'd2,
        BURSTING   = 2'd3
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [1:0]  rst_sync_r;
    logic        run_s;
    logic        ov_s;
    logic        fe_s;
    logic [10:0] total_s;
    logic        fire_s;
    logic [9:0]  ov_cnt_r;
    logic [15:0] timer_r;
    logic        hit_s;
    logic        busy_s;
    logic        hit_r;
    logic        shell_clear_r;
    logic        busy_r;
    logic [7:0]  hit_count_r;

    assign run_s   = rst_sync_r[1];
    assign ov_s    = (bus.tank_icon != 2'd0) && (bus.shell_icon != 2'd0);
    assign fe_s    = (bus.pixel_column == 12'(H_LAST)) && (bus.pixel_row == 12'(V_LAST));
    // The overlap on the frame-end pixel itself still belongs to the closing frame.
    assign total_s = {1'b0, ov_cnt_r} + {10'd0, ov_s};
    assign fire_s  = fe_s && (total_s >= 11'(OVERLAP_MIN));

    // Two-flop synchroniser on reset release; the FSM stays ARMED until it completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    // Per-frame overlap counter, saturating, cleared after every frame end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ov_cnt_r <= 10'd0;
        end else if (fe_s) begin
            ov_cnt_r <= 10'd0;
        end else if (ov_s && (ov_cnt_r != 10'd1023)) begin
            ov_cnt_r <= ov_cnt_r + 10'd1;
        end else begin
            ov_cnt_r <= ov_cnt_r;
        end
    end

    // Burst timeout: loaded while firing, counts down while waiting for the burst.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_r <= 16'd0;
        end else if (state_r == FIRE) begin
            timer_r <= 16'(BURST_TIMEOUT);
        end else if ((state_r == WAIT_BURST) && !bus.burst && !bus.tank_reset
                     && (timer_r != 16'd0)) begin
            timer_r <= timer_r - 16'd1;
        end else begin
            timer_r <= timer_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ARMED;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; burst wins over a coinciding timeout.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ARMED: begin
                if (run_s && fire_s) begin
                    next_state_s = FIRE;
                end else begin
                    next_state_s = ARMED;
                end
            end
            FIRE: begin
                next_state_s = WAIT_BURST;
            end
            WAIT_BURST: begin
                if (bus.burst) begin
                    next_state_s = BURSTING;
                end else if (bus.tank_reset) begin
                    next_state_s = ARMED;
                end else if (timer_r == 16'd0) begin
                    next_state_s = ARMED;
                end else begin
                    next_state_s = WAIT_BURST;
                end
            end
            BURSTING: begin
                if (bus.tank_reset) begin
                    next_state_s = ARMED;
                end else begin
                    next_state_s = BURSTING;
                end
            end
            default: begin
                next_state_s = ARMED;
            end
        endcase
    end

    // FSM output decode from the next state, so the registered outputs align with the state.
    always_comb begin
        hit_s  = 1'b0;
        busy_s = 1'b0;
        if (next_state_s == FIRE) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
        if (next_state_s != ARMED) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
    end

    // Registered outputs and the saturating hit counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_r         <= 1'b0;
            shell_clear_r <= 1'b0;
            busy_r        <= 1'b0;
            hit_count_r   <= 8'd0;
        end else begin
            hit_r         <= hit_s;
            shell_clear_r <= hit_s;
            busy_r        <= busy_s;
            if ((state_r == FIRE) && (hit_count_r != 8'd255)) begin
                hit_count_r <= hit_count_r + 8'd1;
            end else begin
                hit_count_r <= hit_count_r;
            end
        end
    end

    assign bus.hit         = hit_r;
    assign bus.shell_clear = shell_clear_r;
    assign bus.busy        = busy_r;
    assign bus.hit_count   = hit_count_r;

endmodule

// File: tb/tb_tank_hit_detector.sv
// Directed test of tank_hit_detector: overlap thresholds, lockout, timeout, saturation, reset.
module tb_tank_hit_detector;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    int   exp_hc;

    tank_hit_detector_if bus_if ();

    tank_hit_detector #(
        .H_LAST(1023), .V_LAST(767), .OVERLAP_MIN(4), .BURST_TIMEOUT(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus_if.pixel_column = 12'd0;
        bus_if.pixel_row    = 12'd0;
        bus_if.tank_icon    = 2'd0;
        bus_if.shell_icon   = 2'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // n_ov overlapping mid-frame pixels, then the frame-end pixel; returns sampled after fe edge.
    task automatic overlap_frame(input int n_ov, input bit ov_on_fe);
        for (int i = 0; i < n_ov; i++) begin
            bus_if.pixel_column = 12'd100 + 12'(i);
            bus_if.pixel_row    = 12'd200;
            bus_if.tank_icon    = 2'd1 + 2'(i % 3);
            bus_if.shell_icon   = 2'd3 - 2'(i % 3);
            step();
        end
        bus_if.pixel_column = 12'd1023;
        bus_if.pixel_row    = 12'd767;
        bus_if.tank_icon    = ov_on_fe ? 2'd2 : 2'd0;
        bus_if.shell_icon   = 2'd1;
        step();
        idle_inputs();
    endtask

    task automatic expect_fire(input string tag);
        check_eq({tag, "_hit"}, 32'(bus_if.hit), 32'd1);
        check_eq({tag, "_sclr"}, 32'(bus_if.shell_clear), 32'd1);
        check_eq({tag, "_busy"}, 32'(bus_if.busy), 32'd1);
        step();
        if (exp_hc < 255) exp_hc++;
        check_eq({tag, "_hit_lo"}, 32'(bus_if.hit), 32'd0);
        check_eq({tag, "_hc"}, 32'(bus_if.hit_count), 32'(exp_hc));
    endtask

    task automatic rearm();
        bus_if.tank_reset = 1'b1;
        step();
        bus_if.tank_reset = 1'b0;
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        exp_hc = 0;
        reset  = 1'b0;
        bus_if.burst      = 1'b0;
        bus_if.tank_reset = 1'b0;
        idle_inputs();
        #12;
        check_eq("rst_hit", 32'(bus_if.hit), 32'd0);
        check_eq("rst_sclr", 32'(bus_if.shell_clear), 32'd0);
        check_eq("rst_hc", 32'(bus_if.hit_count), 32'd0);
        check_eq("rst_busy", 32'(bus_if.busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) step();

        // 6 overlaps -> single hit pulse
        overlap_frame(6, 1'b0);
        expect_fire("six");
        check_eq("six_busy2", 32'(bus_if.busy), 32'd1);
        rearm();
        check_eq("six_rearm", 32'(bus_if.busy), 32'd0);

        // 3 then 4: counter clears per frame
        overlap_frame(3, 1'b0);
        check_eq("three_nohit", 32'(bus_if.hit), 32'd0);
        check_eq("three_busy", 32'(bus_if.busy), 32'd0);
        overlap_frame(4, 1'b0);
        expect_fire("four");
        rearm();

        // 2 + fe overlap = 3 -> no hit; 3 + fe overlap = 4 -> hit
        overlap_frame(2, 1'b1);
        check_eq("fe3_nohit", 32'(bus_if.hit), 32'd0);
        overlap_frame(3, 1'b1);
        expect_fire("fe4");
        rearm();

        // lockout through burst: overlaps are discarded until tank_reset
        overlap_frame(6, 1'b0);
        expect_fire("lock");
        repeat (4) step();
        bus_if.burst = 1'b1;
        step();
        bus_if.burst = 1'b0;
        check_eq("lock_bursting", 32'(bus_if.busy), 32'd1);
        for (int f = 0; f < 3; f++) begin
            overlap_frame(6, 1'b0);
            check_eq("lock_nohit", 32'(bus_if.hit), 32'd0);
        end
        check_eq("lock_busy", 32'(bus_if.busy), 32'd1);
        check_eq("lock_hc", 32'(bus_if.hit_count), 32'(exp_hc));
        rearm();
        check_eq("lock_release", 32'(bus_if.busy), 32'd0);
        overlap_frame(4, 1'b0);
        expect_fire("second");

        // now in WAIT_BURST with timer 16: 17 cycles there in total
        repeat (16) step();
        check_eq("to_still_busy", 32'(bus_if.busy), 32'd1);
        step();
        check_eq("to_armed", 32'(bus_if.busy), 32'd0);

        // burst on the timeout cycle wins
        overlap_frame(4, 1'b0);
        expect_fire("tob");
        repeat (16) step();
        bus_if.burst = 1'b1;
        step();
        bus_if.burst = 1'b0;
        step();
        check_eq("tob_bursting", 32'(bus_if.busy), 32'd1);
        rearm();
        check_eq("tob_rearm", 32'(bus_if.busy), 32'd0);

        // saturation with fastest re-arm (tank_reset already high in WAIT_BURST)
        while (exp_hc < 258) begin
            overlap_frame(4, 1'b0);
            check_eq("sat_hit", 32'(bus_if.hit), 32'd1);
            bus_if.tank_reset = 1'b1;
            step();
            step();
            bus_if.tank_reset = 1'b0;
            exp_hc++;
            check_eq("sat_hc", 32'(bus_if.hit_count), 32'(exp_hc > 255 ? 255 : exp_hc));
            check_eq("sat_armed", 32'(bus_if.busy), 32'd0);
        end
        exp_hc = 255;

        // async reset mid-BURSTING
        overlap_frame(4, 1'b0);
        expect_fire("last");
        bus_if.burst = 1'b1;
        step();
        check_eq("pre_rst_busy", 32'(bus_if.busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_hit", 32'(bus_if.hit), 32'd0);
        check_eq("arst_sclr", 32'(bus_if.shell_clear), 32'd0);
        check_eq("arst_hc", 32'(bus_if.hit_count), 32'd0);
        check_eq("arst_busy", 32'(bus_if.busy), 32'd0);
        bus_if.burst = 1'b0;
        exp_hc = 0;

        // async reset mid-FIRE truncates hit
        @(negedge clk);
        reset = 1'b1;
        repeat (3) step();
        overlap_frame(4, 1'b0);
        check_eq("fire_hit", 32'(bus_if.hit), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("fire_trunc_hit", 32'(bus_if.hit), 32'd0);
        check_eq("fire_trunc_busy", 32'(bus_if.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
